// File: rtl/ex_mem_stage.sv
// Execute stage with EX/MEM pipeline register: ALU, branch-target adder and a
// shift-add multiplier that holds the upstream pipeline while it iterates.
module ex_mem_stage #(
    parameter int MUL_CYCLES = 32
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        flush_in,
    input  logic [31:0] nextpc,
    input  logic [31:0] reg_file_out_data1,
    input  logic [31:0] reg_file_out_data2,
    input  logic [31:0] sgn_ext_imm_out,
    input  logic [4:0]  rd_in,
    input  logic        reg_write_in,
    input  logic        mem_to_reg_in,
    input  logic        mem_write_in,
    input  logic        mem_read_in,
    input  logic        branch_in,
    input  logic        alu_src_in,
    input  logic [1:0]  alu_op_in,
    output logic        stall_out,
    output logic [31:0] alu_result_out_ex_mem,
    output logic [31:0] store_data_out_ex_mem,
    output logic [31:0] branch_target_out_ex_mem,
    output logic        zero_out_ex_mem,
    output logic [4:0]  rd_out_ex_mem,
    output logic        reg_write_out_ex_mem,
    output logic        mem_to_reg_out_ex_mem,
    output logic        mem_write_out_ex_mem,
    output logic        mem_read_out_ex_mem,
    output logic        branch_out_ex_mem
);

    localparam int              CNT_W    = $clog2(MUL_CYCLES);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(MUL_CYCLES - 1);
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_MUL  = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    state_t             state_q, state_d;
    logic [31:0]        mc_a_q, mc_a_d;
    logic [31:0]        mc_b_q, mc_b_d;
    logic [31:0]        acc_q, acc_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic [4:0]         mul_ctrl_q, mul_ctrl_d;
    logic [4:0]         mul_rd_q, mul_rd_d;

    logic [31:0]        alu_result_q, alu_result_d;
    logic [31:0]        store_data_q, store_data_d;
    logic [31:0]        branch_target_q, branch_target_d;
    logic               zero_q, zero_d;
    logic [4:0]         rd_q, rd_d;
    logic [4:0]         ctrl_q, ctrl_d;

    logic [31:0]        op_b_s;
    logic [5:0]         funct_s;
    logic [31:0]        alu_result_s;
    logic [31:0]        branch_target_s;
    logic [4:0]         ctrl_in_s;
    logic               is_mult_s;
    logic               mult_start_s;

    assign op_b_s          = alu_src_in ? sgn_ext_imm_out : reg_file_out_data2;
    assign funct_s         = sgn_ext_imm_out[5:0];
    assign branch_target_s = nextpc + {sgn_ext_imm_out[29:0], 2'b00};
    assign ctrl_in_s       = {reg_write_in, mem_to_reg_in, mem_write_in, mem_read_in, branch_in};
    assign is_mult_s       = (alu_op_in == 2'b10) && (funct_s == 6'h18);
    assign mult_start_s    = (state_q == ST_IDLE) && is_mult_s;
    assign stall_out       = mult_start_s || (state_q == ST_MUL);

    // Single-cycle ALU; the mult funct yields 0 here since the multiplier owns it
    always_comb begin
        alu_result_s = 32'd0;
        case (alu_op_in)
            2'b00: alu_result_s = reg_file_out_data1 + op_b_s;
            2'b01: alu_result_s = reg_file_out_data1 - op_b_s;
            2'b11: alu_result_s = reg_file_out_data1 | op_b_s;
            2'b10: begin
                case (funct_s)
                    6'h20:   alu_result_s = reg_file_out_data1 + op_b_s;
                    6'h22:   alu_result_s = reg_file_out_data1 - op_b_s;
                    6'h24:   alu_result_s = reg_file_out_data1 & op_b_s;
                    6'h25:   alu_result_s = reg_file_out_data1 | op_b_s;
                    6'h2A:   alu_result_s = ($signed(reg_file_out_data1) < $signed(op_b_s)) ? 32'd1 : 32'd0;
                    default: alu_result_s = 32'd0;
                endcase
            end
            default: alu_result_s = 32'd0;
        endcase
    end

    // Multiplier sequencing; a flush abandons any multiply in flight
    always_comb begin
        state_d    = state_q;
        mc_a_d     = mc_a_q;
        mc_b_d     = mc_b_q;
        acc_d      = acc_q;
        cnt_d      = cnt_q;
        mul_ctrl_d = mul_ctrl_q;
        mul_rd_d   = mul_rd_q;
        case (state_q)
            ST_IDLE: begin
                if (mult_start_s) begin
                    mc_a_d     = reg_file_out_data1;
                    mc_b_d     = op_b_s;
                    acc_d      = 32'd0;
                    cnt_d      = '0;
                    mul_ctrl_d = ctrl_in_s;
                    mul_rd_d   = rd_in;
                    state_d    = ST_MUL;
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_MUL: begin
                if (mc_b_q[0]) begin
                    acc_d = acc_q + mc_a_q;
                end else begin
                    acc_d = acc_q;
                end
                mc_a_d = {mc_a_q[30:0], 1'b0};
                mc_b_d = {1'b0, mc_b_q[31:1]};
                cnt_d  = cnt_q + CNT_ONE;
                if (cnt_q == CNT_LAST) begin
                    state_d = ST_DONE;
                end else begin
                    state_d = ST_MUL;
                end
            end
            ST_DONE: state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase
        if (flush_in) begin
            state_d = ST_IDLE;
        end else begin
            state_d = state_d;
        end
    end

    // Next EX/MEM contents: bubble, finished multiply, or the ALU result
    always_comb begin
        alu_result_d    = 32'd0;
        store_data_d    = 32'd0;
        branch_target_d = 32'd0;
        zero_d          = 1'b0;
        rd_d            = 5'd0;
        ctrl_d          = 5'd0;
        if (flush_in || stall_out) begin
            alu_result_d = 32'd0;
        end else if (state_q == ST_DONE) begin
            alu_result_d    = acc_q;
            store_data_d    = reg_file_out_data2;
            branch_target_d = branch_target_s;
            zero_d          = (acc_q == 32'd0);
            rd_d            = mul_rd_q;
            ctrl_d          = mul_ctrl_q;
        end else begin
            alu_result_d    = alu_result_s;
            store_data_d    = reg_file_out_data2;
            branch_target_d = branch_target_s;
            zero_d          = (alu_result_s == 32'd0);
            rd_d            = rd_in;
            ctrl_d          = ctrl_in_s;
        end
    end

    // State and pipeline register update with synchronous active-low reset
    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q         <= ST_IDLE;
            mc_a_q          <= 32'd0;
            mc_b_q          <= 32'd0;
            acc_q           <= 32'd0;
            cnt_q           <= '0;
            mul_ctrl_q      <= 5'd0;
            mul_rd_q        <= 5'd0;
            alu_result_q    <= 32'd0;
            store_data_q    <= 32'd0;
            branch_target_q <= 32'd0;
            zero_q          <= 1'b0;
            rd_q            <= 5'd0;
            ctrl_q          <= 5'd0;
        end else begin
            state_q         <= state_d;
            mc_a_q          <= mc_a_d;
            mc_b_q          <= mc_b_d;
            acc_q           <= acc_d;
            cnt_q           <= cnt_d;
            mul_ctrl_q      <= mul_ctrl_d;
            mul_rd_q        <= mul_rd_d;
            alu_result_q    <= alu_result_d;
            store_data_q    <= store_data_d;
            branch_target_q <= branch_target_d;
            zero_q          <= zero_d;
            rd_q            <= rd_d;
            ctrl_q          <= ctrl_d;
        end
    end

    assign alu_result_out_ex_mem    = alu_result_q;
    assign store_data_out_ex_mem    = store_data_q;
    assign branch_target_out_ex_mem = branch_target_q;
    assign zero_out_ex_mem          = zero_q;
    assign rd_out_ex_mem            = rd_q;
    assign reg_write_out_ex_mem     = ctrl_q[4];
    assign mem_to_reg_out_ex_mem    = ctrl_q[3];
    assign mem_write_out_ex_mem     = ctrl_q[2];
    assign mem_read_out_ex_mem      = ctrl_q[1];
    assign branch_out_ex_mem        = ctrl_q[0];

endmodule

// File: tb/tb_ex_mem_stage.sv
// Self-checking bench for ex_mem_stage: directed vector table, multiply/flush/reset
// sequences, and randomized ALU/multiply traffic against a behavioural model.
module tb_ex_mem_stage;

    logic        clk;
    logic        reset;
    logic        flush_in;
    logic [31:0] nextpc;
    logic [31:0] data1;
    logic [31:0] data2;
    logic [31:0] imm;
    logic [4:0]  rd_in;
    logic        reg_write_in, mem_to_reg_in, mem_write_in, mem_read_in, branch_in;
    logic        alu_src_in;
    logic [1:0]  alu_op_in;
    logic        stall_out;
    logic [31:0] alu_result_out, store_data_out, branch_target_out;
    logic        zero_out;
    logic [4:0]  rd_out;
    logic        reg_write_out, mem_to_reg_out, mem_write_out, mem_read_out, branch_out;

    int n_total = 0;
    int n_pass  = 0;

    ex_mem_stage dut (
        .clk                      (clk),
        .reset                    (reset),
        .flush_in                 (flush_in),
        .nextpc                   (nextpc),
        .reg_file_out_data1       (data1),
        .reg_file_out_data2       (data2),
        .sgn_ext_imm_out          (imm),
        .rd_in                    (rd_in),
        .reg_write_in             (reg_write_in),
        .mem_to_reg_in            (mem_to_reg_in),
        .mem_write_in             (mem_write_in),
        .mem_read_in              (mem_read_in),
        .branch_in                (branch_in),
        .alu_src_in               (alu_src_in),
        .alu_op_in                (alu_op_in),
        .stall_out                (stall_out),
        .alu_result_out_ex_mem    (alu_result_out),
        .store_data_out_ex_mem    (store_data_out),
        .branch_target_out_ex_mem (branch_target_out),
        .zero_out_ex_mem          (zero_out),
        .rd_out_ex_mem            (rd_out),
        .reg_write_out_ex_mem     (reg_write_out),
        .mem_to_reg_out_ex_mem    (mem_to_reg_out),
        .mem_write_out_ex_mem     (mem_write_out),
        .mem_read_out_ex_mem      (mem_read_out),
        .branch_out_ex_mem        (branch_out)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [1:0]  op;
        logic        src;
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] imm;
        logic [31:0] npc;
        logic [4:0]  rd;
        logic [4:0]  ctrl;
        logic [31:0] exp_res;
        logic        exp_zero;
    } vec_t;

    vec_t tbl[10];

    task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
        n_total++;
        if (act === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic apply(input logic [1:0] op, input logic src, input logic [31:0] a,
                         input logic [31:0] b, input logic [31:0] im, input logic [31:0] npc,
                         input logic [4:0] rd, input logic [4:0] ctrl);
        alu_op_in     = op;
        alu_src_in    = src;
        data1         = a;
        data2         = b;
        imm           = im;
        nextpc        = npc;
        rd_in         = rd;
        reg_write_in  = ctrl[4];
        mem_to_reg_in = ctrl[3];
        mem_write_in  = ctrl[2];
        mem_read_in   = ctrl[1];
        branch_in     = ctrl[0];
    endtask

    function automatic logic [4:0] ctrl_out();
        return {reg_write_out, mem_to_reg_out, mem_write_out, mem_read_out, branch_out};
    endfunction

    function automatic logic [106:0] outs_all();
        return {alu_result_out, store_data_out, branch_target_out, zero_out, rd_out, ctrl_out()};
    endfunction

    // Behavioural model: what the instruction computes, straight from the ISA rules
    function automatic logic [31:0] ref_result(input logic [1:0] op, input logic src,
                                               input logic [31:0] a, input logic [31:0] b,
                                               input logic [31:0] im);
        logic [31:0] bb;
        logic [63:0] prod;
        bb   = src ? im : b;
        prod = {32'd0, a} * {32'd0, bb};
        if (op == 2'b00) return a + bb;
        if (op == 2'b01) return a - bb;
        if (op == 2'b11) return a | bb;
        if (im[5:0] == 6'h20) return a + bb;
        if (im[5:0] == 6'h22) return a - bb;
        if (im[5:0] == 6'h24) return a & bb;
        if (im[5:0] == 6'h25) return a | bb;
        if (im[5:0] == 6'h2A) return (int'(a) < int'(bb)) ? 32'd1 : 32'd0;
        if (im[5:0] == 6'h18) return prod[31:0];
        return 32'd0;
    endfunction

    function automatic logic [31:0] ref_target(input logic [31:0] npc, input logic [31:0] im);
        return npc + im * 32'd4;
    endfunction

    task automatic run_mult(input logic [31:0] a, input logic [31:0] b,
                            input logic [4:0] rd, input logic [4:0] ctrl);
        int stall_cnt;
        int bubble_cnt;
        logic [31:0] npc;
        logic [31:0] exp;
        stall_cnt  = 0;
        bubble_cnt = 0;
        npc        = $urandom;
        exp        = ref_result(2'b10, 1'b0, a, b, 32'h0000_0018);
        apply(2'b10, 1'b0, a, b, 32'h0000_0018, npc, rd, ctrl);
        #1;
        for (int i = 0; i < 40; i++) begin
            if (!stall_out) break;
            stall_cnt++;
            step();
            if (outs_all() == 107'd0) bubble_cnt++;
        end
        check("mult_stall_cycles", stall_cnt, 33);
        check("mult_bubbles", bubble_cnt, 33);
        check("mult_stall_low_done", stall_out, 1'b0);
        step();
        check("mult_result", alu_result_out, exp);
        check("mult_zero", zero_out, exp == 32'd0);
        check("mult_rd", rd_out, rd);
        check("mult_ctrl", ctrl_out(), ctrl);
        check("mult_store", store_data_out, b);
        check("mult_target", branch_target_out, ref_target(npc, 32'h0000_0018));
    endtask

    initial begin
        logic [5:0]  functs[8];
        logic [1:0]  op;
        logic        src;
        logic [31:0] a, b, im, npc;
        logic [4:0]  rd, ctrl;

        functs = '{6'h20, 6'h22, 6'h24, 6'h25, 6'h2A, 6'h3F, 6'h00, 6'h19};

        tbl[0] = '{2'b00, 1'b1, 32'h0000_0100, 32'h0000_0055, 32'hFFFF_FFFC, 32'h0000_0010, 5'd3, 5'b11010, 32'h0000_00FC, 1'b0};
        tbl[1] = '{2'b01, 1'b0, 32'h0000_0007, 32'h0000_0007, 32'h0000_0003, 32'h0000_0040, 5'd0, 5'b00001, 32'h0000_0000, 1'b1};
        tbl[2] = '{2'b10, 1'b0, 32'hFFFF_FFFF, 32'h0000_0001, 32'h0000_002A, 32'h0000_0100, 5'd4, 5'b10000, 32'h0000_0001, 1'b0};
        tbl[3] = '{2'b10, 1'b0, 32'hFFFF_FFFF, 32'h0000_0002, 32'h0000_0020, 32'h0000_0104, 5'd5, 5'b10000, 32'h0000_0001, 1'b0};
        tbl[4] = '{2'b10, 1'b0, 32'h0000_0005, 32'h0000_0007, 32'h0000_0022, 32'h0000_0108, 5'd6, 5'b10000, 32'hFFFF_FFFE, 1'b0};
        tbl[5] = '{2'b10, 1'b0, 32'h0000_F0F0, 32'h0000_FF00, 32'h0000_0024, 32'h0000_010C, 5'd7, 5'b10000, 32'h0000_F000, 1'b0};
        tbl[6] = '{2'b10, 1'b0, 32'h0000_F0F0, 32'h0000_0F0F, 32'h0000_0025, 32'h0000_0110, 5'd8, 5'b10000, 32'h0000_FFFF, 1'b0};
        tbl[7] = '{2'b11, 1'b1, 32'h0000_1200, 32'h0000_DEAD, 32'h0000_0034, 32'h0000_0114, 5'd9, 5'b10000, 32'h0000_1234, 1'b0};
        tbl[8] = '{2'b10, 1'b0, 32'h0000_0003, 32'h0000_0004, 32'h0000_003F, 32'h0000_0118, 5'd10, 5'b10000, 32'h0000_0000, 1'b1};
        tbl[9] = '{2'b10, 1'b0, 32'h0000_0001, 32'hFFFF_FFFF, 32'h0000_002A, 32'h0000_011C, 5'd11, 5'b10100, 32'h0000_0000, 1'b1};

        // Reset with random non-multiply inputs
        reset    = 1'b0;
        flush_in = 1'b0;
        apply(2'b00, 1'b1, $urandom, $urandom, $urandom, $urandom, 5'($urandom), 5'($urandom));
        step();
        step();
        check("reset_outputs", outs_all(), 107'd0);
        check("reset_stall", stall_out, 1'b0);
        reset = 1'b1;

        // Directed vector table
        for (int i = 0; i < 10; i++) begin
            apply(tbl[i].op, tbl[i].src, tbl[i].a, tbl[i].b, tbl[i].imm, tbl[i].npc, tbl[i].rd, tbl[i].ctrl);
            #1;
            check($sformatf("vec%0d_stall", i), stall_out, 1'b0);
            step();
            check($sformatf("vec%0d_result", i), alu_result_out, tbl[i].exp_res);
            check($sformatf("vec%0d_zero", i), zero_out, tbl[i].exp_zero);
            check($sformatf("vec%0d_store", i), store_data_out, tbl[i].b);
            check($sformatf("vec%0d_rd", i), rd_out, tbl[i].rd);
            check($sformatf("vec%0d_ctrl", i), ctrl_out(), tbl[i].ctrl);
            check($sformatf("vec%0d_target", i), branch_target_out, ref_target(tbl[i].npc, tbl[i].imm));
        end
        check("beq_target_const", branch_target_out == 32'h0000_011C + 32'h0000_00A8, 1'b1);

        // Multiply then a trailing add
        run_mult(32'h0001_0003, 32'h0000_0005, 5'd9, 5'b10000);
        check("mult_example_value", alu_result_out, 32'h0005_000F);
        apply(2'b10, 1'b0, 32'd10, 32'd20, 32'h0000_0020, 32'h0000_0200, 5'd12, 5'b10000);
        step();
        check("add_after_mult", alu_result_out, 32'd30);
        check("add_after_mult_rd", rd_out, 5'd12);

        // Flush ten cycles into MUL
        apply(2'b10, 1'b0, 32'h0000_1234, 32'h0000_0077, 32'h0000_0018, 32'h0, 5'd13, 5'b10000);
        step();
        repeat (10) step();
        flush_in = 1'b1;
        apply(2'b10, 1'b0, 32'd1, 32'd2, 32'h0000_0020, 32'h0000_0300, 5'd14, 5'b10000);
        step();
        flush_in = 1'b0;
        check("flush_bubble", outs_all(), 107'd0);
        check("flush_stall_low", stall_out, 1'b0);
        step();
        check("flush_next_add", alu_result_out, 32'd3);
        check("flush_next_rd", rd_out, 5'd14);
        run_mult(32'h0000_0102, 32'h0000_0304, 5'd15, 5'b11000);

        // Reset at counter = 20
        apply(2'b10, 1'b0, 32'hDEAD_BEEF, 32'h0000_0033, 32'h0000_0018, 32'h0, 5'd16, 5'b10000);
        step();
        repeat (20) step();
        reset = 1'b0;
        step();
        check("midreset_outputs", outs_all(), 107'd0);
        reset = 1'b1;
        run_mult(32'h0000_0ABC, 32'h0001_0001, 5'd17, 5'b10000);

        // Random multiplies
        for (int i = 0; i < 4; i++) begin
            run_mult($urandom, (i == 3) ? 32'd0 : $urandom, 5'($urandom), 5'($urandom));
        end

        // Random single-cycle traffic
        for (int i = 0; i < 150; i++) begin
            op   = 2'($urandom_range(0, 3));
            src  = 1'($urandom);
            a    = (i % 7 == 0) ? 32'h8000_0000 : $urandom;
            b    = (i % 5 == 0) ? a : $urandom;
            im   = $urandom;
            if (op == 2'b10) im[5:0] = functs[$urandom_range(0, 7)];
            npc  = $urandom;
            rd   = 5'($urandom);
            ctrl = 5'($urandom);
            apply(op, src, a, b, im, npc, rd, ctrl);
            step();
            check("rand_result", alu_result_out, ref_result(op, src, a, b, im));
            check("rand_zero", zero_out, ref_result(op, src, a, b, im) == 32'd0);
            check("rand_target", branch_target_out, ref_target(npc, im));
            check("rand_ctrl_rd", {ctrl_out(), rd_out, store_data_out}, {ctrl, rd, b});
        end

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
